zube_mailbox: RTL and testbench
===============================

Name: zube_mailbox

Overview:
Parametrised successor to the single-register Zube host/external link. Two independent DEPTH-entry FIFOs, host-to-ext (H2E) and ext-to-host (E2H), plus a status mailbox register in each direction. Wishbone slave on the Caravel side; an asynchronous strobed parallel bus on GPIO on the other side. Drives the data and status user IRQs. Instantiated in user_project_wrapper in place of the previous Zube core.

Parameters:
DATA_W, 8, FIFO/mailbox data width (1..16)
DEPTH, 8, entries per FIFO; power of two, 2..128
BASE_ADDR, 32'h3000_0000, Wishbone base; decode on wb_addr_in[31:5]
IRQ_THRESH, 1, E2H count at or above which the data IRQ asserts (1..DEPTH)

Ports:
clk  in  1  system clock (wb_clk_i)
reset  in  1  asynchronous, active-high reset
wb_cyc_in  in  1  Wishbone cycle
wb_stb_in  in  1  Wishbone strobe
wb_we_in  in  1  Wishbone write enable
wb_addr_in  in  32  Wishbone byte address
wb_data_in  in  32  Wishbone write data
wb_ack_out  out  1  Wishbone acknowledge
wb_data_out  out  32  Wishbone read data
ext_addr_in  in  2  external register select
ext_data_in  in  DATA_W  external write data
ext_data_out  out  DATA_W  external read data
ext_data_oe  out  1  drive enable for ext_data_out; wrapper inverts it for io_oeb
ext_rd_in  in  1  external read strobe, active-high, asynchronous
ext_wr_in  in  1  external write strobe, active-high, asynchronous
irq_data_out  out  1  E2H data-available interrupt
irq_status_out  out  1  external-status-written interrupt

Behaviour:
- Reset: all outputs 0, FIFOs empty, all registers and sticky flags 0.
- Wishbone handshake:
  - wb_ack_out pulses 1 cycle, the cycle after wb_cyc_in&wb_stb_in&!wb_ack_out.
  - wb_data_out is valid with ack and 0 otherwise.
  - An unmatched base address is still acked: reads return 0, writes are ignored.
  - Side effects (push/pop/clear) happen once, in the ack cycle.
- Wishbone map (word offset wb_addr_in[4:2]):
  - 0 DATA: write pushes wb_data_in[DATA_W-1:0] to H2E; read pops E2H.
  - 1 STATUS: [7:0] h2e_count, [15:8] e2h_count, 16 h2e_full, 17 e2h_empty, 18 h2e_ovf, 19 h2e_unf, 20 e2h_ovf, 21 e2h_unf. Writing 1 to bits 18..21 clears those flags.
  - 2 HOST_STAT: RW DATA_W register.
  - 3 EXT_STAT: RO; a read clears status_pend.
  - 4 IRQ_EN: bit0 data, bit1 status.
  - 5 IRQ_PEND: RO; bit0 = e2h_count>=IRQ_THRESH, bit1 = status_pend.
  - 6,7: read 0.
- External side:
  - ext_rd_in and ext_wr_in each pass through a 2-flop synchroniser, then a rising-edge detect (3rd flop).
  - ext_addr_in and ext_data_in are sampled in the edge cycle. The external master holds them stable from 3 clk before its strobe edge until the strobe falls.
  - Action occurs 3 clk after the asynchronous edge.
- External map:
  - Read addr 0: pop H2E into the ext_data_out register.
  - Read addr 1: {.., e2h_full, h2e_empty} in bits [1:0].
  - Read addr 3: HOST_STAT.
  - Write addr 0: push E2H.
  - Write addr 2: load EXT_STAT and set status_pend.
  - Other accesses: no effect; a read returns 0.
  - ext_data_out holds its value until the next read edge.
  - ext_data_oe = synchronised rd level.
- FIFO rules:
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; count = wr_ptr - rd_ptr.
  - Push when full with no simultaneous pop: data dropped, *_ovf set.
  - Pop when empty: returns 0, *_unf set, pointers unchanged.
  - Simultaneous push+pop when full: both succeed, count unchanged.
  - Simultaneous push+pop when empty: pop underflows and returns 0; push succeeds.
- Simultaneous events:
  - Ext write to EXT_STAT in the same cycle as a WB read of EXT_STAT: the read returns the old value; the set wins, so status_pend=1.
  - Sticky flag set and W1C in the same cycle: set wins.
- Interrupts (registered, 1-cycle latency from cause):
  - irq_data_out = IRQ_EN[0] & (e2h_count>=IRQ_THRESH).
  - irq_status_out = IRQ_EN[1] & status_pend.
- Reset mid-transaction: asynchronous clear of everything, including a pending ack and the synchronisers. There is no partial push or pop.

Test Plan:
- Reset -> wb_ack_out=0, irq outputs=0, STATUS read=32'h0002_0000 (e2h_empty=1, all else 0).
- WB writes 0x11,0x22,0x33 to DATA; 3 ext reads at addr 0 -> ext_data_out 0x11,0x22,0x33; 4th read -> 0x00 and STATUS[19]=1; W1C bit19 -> STATUS[19]=0.
- IRQ_EN=1, IRQ_THRESH=1; ext write 0xA5 at addr 0 -> irq_data_out=1 within 5 clk of the strobe edge; WB DATA read -> 0xA5, irq_data_out=0 next cycle.
- DEPTH=8: 9 WB pushes -> h2e_count=8, h2e_full=1, h2e_ovf=1, 9th value never read externally; push+pop in the same cycle when full -> count stays 8.
- IRQ_EN=2; ext write 0x5C at addr 2 -> irq_status_out=1; WB read EXT_STAT -> 0x5C, irq_status_out=0; same-cycle ext write and WB read -> irq_status_out stays 1.
- Assert reset mid-ack with FIFOs half full -> ack drops immediately, counts=0, ext_data_out=0.

Source files
------------

// File: rtl/zube_mailbox.sv
// Zube host/external mailbox: two FIFOs (H2E, E2H) plus status mailboxes,
// a Wishbone slave on the Caravel side and a strobed async bus on GPIO.

module zube_mailbox_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push
    always_comb begin
        count    = wr_ptr - rd_ptr;
        empty    = (count == '0);
        full     = (count == FULL_C);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | pop);
        ovf      = push & full & ~pop;
        unf      = pop & empty;
        pop_data = do_pop ? mem[rd_ptr[AW-1:0]] : '0;
    end

    // Storage and wrap-around pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module zube_mailbox #(
    parameter int          DATA_W     = 8,
    parameter int          DEPTH      = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          IRQ_THRESH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_in,
    input  logic              wb_stb_in,
    input  logic              wb_we_in,
    input  logic [31:0]       wb_addr_in,
    input  logic [31:0]       wb_data_in,
    output logic              wb_ack_out,
    output logic [31:0]       wb_data_out,
    input  logic [1:0]        ext_addr_in,
    input  logic [DATA_W-1:0] ext_data_in,
    output logic [DATA_W-1:0] ext_data_out,
    output logic              ext_data_oe,
    input  logic              ext_rd_in,
    input  logic              ext_wr_in,
    output logic              irq_data_out,
    output logic              irq_status_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(IRQ_THRESH);

    logic [31:2]       lat_addr;
    logic [31:0]       lat_data;
    logic              lat_we;
    logic              wb_req, wb_hit, wb_wr, wb_rd;
    logic [2:0]        sel;
    logic [2:0]        rd_sync, wr_sync;
    logic              rd_edge, wr_edge;
    logic [DATA_W-1:0] host_stat, ext_stat;
    logic              status_pend;
    logic [1:0]        irq_en;
    logic [3:0]        flags;
    logic [3:0]        flag_set, flag_clr;
    logic              h2e_push, h2e_pop, e2h_push, e2h_pop;
    logic [DATA_W-1:0] h2e_pop_data, e2h_pop_data;
    logic [AW:0]       h2e_count, e2h_count;
    logic              h2e_empty, h2e_full, e2h_empty, e2h_full;
    logic              h2e_ovf, h2e_unf, e2h_ovf, e2h_unf;
    logic              e2h_above;
    logic [31:0]       status_word;
    logic [1:0]        ext_flags;
    logic              unused_bits;

    assign unused_bits = ^{lat_data, wb_addr_in[1:0]};

    // Request decode; the ack cycle is where every Wishbone side effect lands
    always_comb begin
        wb_req    = wb_cyc_in & wb_stb_in & ~wb_ack_out;
        wb_hit    = (lat_addr[31:5] == BASE_ADDR[31:5]);
        sel       = lat_addr[4:2];
        wb_wr     = wb_ack_out & wb_hit & lat_we;
        wb_rd     = wb_ack_out & wb_hit & ~lat_we;
        rd_edge   = rd_sync[1] & ~rd_sync[2];
        wr_edge   = wr_sync[1] & ~wr_sync[2];
        h2e_push  = wb_wr & (sel == 3'd0);
        e2h_pop   = wb_rd & (sel == 3'd0);
        h2e_pop   = rd_edge & (ext_addr_in == 2'd0);
        e2h_push  = wr_edge & (ext_addr_in == 2'd0);
        e2h_above = (e2h_count >= THRESH_C);
        flag_set  = {e2h_unf, e2h_ovf, h2e_unf, h2e_ovf};
        flag_clr  = (wb_wr && sel == 3'd1) ? lat_data[21:18] : 4'b0;
        ext_flags = {e2h_full, h2e_empty};
        ext_data_oe = rd_sync[1];
        status_word = {10'b0, flags, e2h_empty, h2e_full,
                       8'(e2h_count), 8'(h2e_count)};
    end

    // Wishbone ack and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_out <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
        end else begin
            wb_ack_out <= wb_req;
            if (wb_req) begin
                lat_we   <= wb_we_in;
                lat_addr <= wb_addr_in[31:2];
                lat_data <= wb_data_in;
            end
        end
    end

    // Read mux, driven only while acking a matched address
    always_comb begin
        wb_data_out = '0;
        if (wb_rd) begin
            case (sel)
                3'd0:    wb_data_out = 32'(e2h_pop_data);
                3'd1:    wb_data_out = status_word;
                3'd2:    wb_data_out = 32'(host_stat);
                3'd3:    wb_data_out = 32'(ext_stat);
                3'd4:    wb_data_out = {30'b0, irq_en};
                3'd5:    wb_data_out = {30'b0, status_pend, e2h_above};
                default: wb_data_out = '0;
            endcase
        end
    end

    // Strobe synchronisers with a third flop for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sync <= '0;
            wr_sync <= '0;
        end else begin
            rd_sync <= {rd_sync[1:0], ext_rd_in};
            wr_sync <= {wr_sync[1:0], ext_wr_in};
        end
    end

    // External read data register, held until the next read edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_data_out <= '0;
        end else if (rd_edge) begin
            case (ext_addr_in)
                2'd0:    ext_data_out <= h2e_pop_data;
                2'd1:    ext_data_out <= DATA_W'(ext_flags);
                2'd3:    ext_data_out <= host_stat;
                default: ext_data_out <= '0;
            endcase
        end
    end

    // Control/status registers; sticky sets beat a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_stat   <= '0;
            ext_stat    <= '0;
            status_pend <= 1'b0;
            irq_en      <= '0;
            flags       <= '0;
        end else begin
            if (wb_wr && sel == 3'd2) host_stat <= lat_data[DATA_W-1:0];
            if (wb_wr && sel == 3'd4) irq_en    <= lat_data[1:0];
            if (wr_edge && ext_addr_in == 2'd2) ext_stat <= ext_data_in;
            status_pend <= (wr_edge && ext_addr_in == 2'd2) |
                           (status_pend & ~(wb_rd && sel == 3'd3));
            flags <= (flags & ~flag_clr) | flag_set;
        end
    end

    // Registered interrupt outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_data_out   <= 1'b0;
            irq_status_out <= 1'b0;
        end else begin
            irq_data_out   <= irq_en[0] & e2h_above;
            irq_status_out <= irq_en[1] & status_pend;
        end
    end

    zube_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_h2e (
        .clk(clk), .reset(reset),
        .push(h2e_push), .pop(h2e_pop),
        .push_data(lat_data[DATA_W-1:0]), .pop_data(h2e_pop_data),
        .count(h2e_count), .empty(h2e_empty), .full(h2e_full),
        .ovf(h2e_ovf), .unf(h2e_unf)
    );

    zube_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_e2h (
        .clk(clk), .reset(reset),
        .push(e2h_push), .pop(e2h_pop),
        .push_data(ext_data_in), .pop_data(e2h_pop_data),
        .count(e2h_count), .empty(e2h_empty), .full(e2h_full),
        .ovf(e2h_ovf), .unf(e2h_unf)
    );
endmodule

// File: tb/tb_zube_mailbox.sv
// Directed self-checking bench for zube_mailbox (DATA_W=8, DEPTH=8, IRQ_THRESH=1).

module tb_zube_mailbox;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_cyc_in = 1'b0, wb_stb_in = 1'b0, wb_we_in = 1'b0;
    logic [31:0] wb_addr_in = '0, wb_data_in = '0;
    logic        wb_ack_out;
    logic [31:0] wb_data_out;
    logic [1:0]  ext_addr_in = '0;
    logic [7:0]  ext_data_in = '0;
    logic [7:0]  ext_data_out;
    logic        ext_data_oe;
    logic        ext_rd_in = 1'b0, ext_wr_in = 1'b0;
    logic        irq_data_out, irq_status_out;

    int tests = 0;
    int fails = 0;

    zube_mailbox #(.DATA_W(8), .DEPTH(8), .BASE_ADDR(BASE), .IRQ_THRESH(1)) dut (
        .clk(clk), .reset(reset),
        .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
        .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out),
        .ext_addr_in(ext_addr_in), .ext_data_in(ext_data_in),
        .ext_data_out(ext_data_out), .ext_data_oe(ext_data_oe),
        .ext_rd_in(ext_rd_in), .ext_wr_in(ext_wr_in),
        .irq_data_out(irq_data_out), .irq_status_out(irq_status_out)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        wb_cyc_in = 0; wb_stb_in = 0; wb_we_in = 0;
        ext_rd_in = 0; ext_wr_in = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = we;
        wb_addr_in = addr; wb_data_in = wdata;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb_ack_out && n < 8);
        tests++;
        if (wb_ack_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wb_ack addr=%h got=%b want=1", addr, wb_ack_out);
        end
        rdata = wb_data_out;
        wb_cyc_in = 0; wb_stb_in = 0; wb_we_in = 0;
    endtask

    task automatic wb_write(input int off, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, BASE + 32'(off * 4), d, dummy);
    endtask

    task automatic wb_read(input int off, output logic [31:0] d);
        wb_access(1'b0, BASE + 32'(off * 4), 32'h0, d);
    endtask

    task automatic ext_access(input logic wr, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ext_addr_in = a; ext_data_in = d;
        repeat (3) @(negedge clk);
        if (wr) ext_wr_in = 1; else ext_rd_in = 1;
        repeat (5) @(negedge clk);
        ext_wr_in = 0; ext_rd_in = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (wb_ack_out !== 1'b0 || irq_data_out !== 1'b0 || irq_status_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got ack=%b irqd=%b irqs=%b want 0 0 0",
                     wb_ack_out, irq_data_out, irq_status_out);
        end
        tests++;
        if (ext_data_out !== 8'h00 || ext_data_oe !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ext got data=%h oe=%b want 00 0", ext_data_out, ext_data_oe);
        end
        apply_reset();
        wb_read(1, d);
        tests++;
        if (d !== 32'h0002_0000) begin
            fails++;
            $display("[TB] FAIL reset_status got=%h want=00020000", d);
        end
    endtask

    task automatic test_h2e_basic();
        logic [31:0] d;
        logic [7:0]  vals [3] = '{8'h11, 8'h22, 8'h33};
        apply_reset();
        for (int i = 0; i < 3; i++) wb_write(0, 32'(vals[i]));
        wb_read(1, d);
        tests++;
        if (d !== 32'h0002_0003) begin
            fails++;
            $display("[TB] FAIL h2e_count3 got=%h want=00020003", d);
        end
        for (int i = 0; i < 3; i++) begin
            ext_access(1'b0, 2'd0, 8'h00);
            tests++;
            if (ext_data_out !== vals[i]) begin
                fails++;
                $display("[TB] FAIL h2e_pop%0d got=%h want=%h", i, ext_data_out, vals[i]);
            end
        end
        ext_access(1'b0, 2'd0, 8'h00);
        tests++;
        if (ext_data_out !== 8'h00) begin
            fails++;
            $display("[TB] FAIL h2e_underflow_data got=%h want=00", ext_data_out);
        end
        wb_read(1, d);
        tests++;
        if (d !== 32'h000A_0000) begin
            fails++;
            $display("[TB] FAIL h2e_unf_flag got=%h want=000a0000", d);
        end
        wb_write(1, 32'h0008_0000);
        wb_read(1, d);
        tests++;
        if (d !== 32'h0002_0000) begin
            fails++;
            $display("[TB] FAIL h2e_unf_w1c got=%h want=00020000", d);
        end
    endtask

    task automatic test_irq_data();
        logic [31:0] d;
        int n;
        apply_reset();
        wb_write(4, 32'h1);
        @(negedge clk);
        ext_addr_in = 2'd0; ext_data_in = 8'hA5;
        repeat (3) @(negedge clk);
        ext_wr_in = 1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!irq_data_out && n < 5);
        tests++;
        if (irq_data_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL irq_data_rise got=%b want=1 after %0d clk", irq_data_out, n);
        end
        repeat (3) @(negedge clk);
        ext_wr_in = 0;
        repeat (4) @(negedge clk);
        wb_read(5, d);
        tests++;
        if (d !== 32'h0000_0001) begin
            fails++;
            $display("[TB] FAIL irq_pend_data got=%h want=00000001", d);
        end
        wb_read(1, d);
        tests++;
        if (d !== 32'h0000_0100) begin
            fails++;
            $display("[TB] FAIL e2h_count1 got=%h want=00000100", d);
        end
        wb_read(0, d);
        tests++;
        if (d !== 32'h0000_00A5) begin
            fails++;
            $display("[TB] FAIL e2h_pop got=%h want=000000a5", d);
        end
        @(posedge clk); @(posedge clk); #1;
        tests++;
        if (irq_data_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL irq_data_fall got=%b want=0", irq_data_out);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  exp_v [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        apply_reset();
        for (int i = 1; i <= 9; i++) wb_write(0, 32'(i));
        wb_read(1, d);
        tests++;
        if (d !== 32'h0007_0008) begin
            fails++;
            $display("[TB] FAIL h2e_full_ovf got=%h want=00070008", d);
        end
        // Line up an external pop and a WB push on the same clock edge
        @(negedge clk);
        ext_addr_in = 2'd0;
        repeat (3) @(negedge clk);
        ext_rd_in = 1;
        @(negedge clk);
        wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = 1;
        wb_addr_in = BASE; wb_data_in = 32'h0A;
        @(posedge clk); #1;
        tests++;
        if (wb_ack_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pushpop_ack got=%b want=1", wb_ack_out);
        end
        wb_cyc_in = 0; wb_stb_in = 0; wb_we_in = 0;
        repeat (4) @(negedge clk);
        ext_rd_in = 0;
        repeat (4) @(negedge clk);
        tests++;
        if (ext_data_out !== 8'h01) begin
            fails++;
            $display("[TB] FAIL pushpop_data got=%h want=01", ext_data_out);
        end
        wb_read(1, d);
        tests++;
        if (d !== 32'h0007_0008) begin
            fails++;
            $display("[TB] FAIL pushpop_count got=%h want=00070008", d);
        end
        for (int i = 0; i < 8; i++) begin
            ext_access(1'b0, 2'd0, 8'h00);
            tests++;
            if (ext_data_out !== exp_v[i]) begin
                fails++;
                $display("[TB] FAIL drain%0d got=%h want=%h", i, ext_data_out, exp_v[i]);
            end
        end
        wb_read(1, d);
        tests++;
        if (d !== 32'h0006_0000) begin
            fails++;
            $display("[TB] FAIL drain_status got=%h want=00060000", d);
        end
    endtask

    task automatic test_status_mbox();
        logic [31:0] d;
        apply_reset();
        wb_write(4, 32'h2);
        ext_access(1'b1, 2'd2, 8'h5C);
        tests++;
        if (irq_status_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL irq_status_rise got=%b want=1", irq_status_out);
        end
        wb_read(5, d);
        tests++;
        if (d !== 32'h0000_0002) begin
            fails++;
            $display("[TB] FAIL irq_pend_status got=%h want=00000002", d);
        end
        wb_read(3, d);
        tests++;
        if (d !== 32'h0000_005C) begin
            fails++;
            $display("[TB] FAIL ext_stat_read got=%h want=0000005c", d);
        end
        @(posedge clk); @(posedge clk); #1;
        tests++;
        if (irq_status_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL irq_status_fall got=%b want=0", irq_status_out);
        end
        // External load of EXT_STAT on the same edge as the WB read clearing it
        @(negedge clk);
        ext_addr_in = 2'd2; ext_data_in = 8'h77;
        repeat (3) @(negedge clk);
        ext_wr_in = 1;
        @(negedge clk);
        wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = 0; wb_addr_in = BASE + 32'hC;
        @(posedge clk); #1;
        d = wb_data_out;
        wb_cyc_in = 0; wb_stb_in = 0;
        tests++;
        if (d !== 32'h0000_005C) begin
            fails++;
            $display("[TB] FAIL race_old_value got=%h want=0000005c", d);
        end
        repeat (4) @(negedge clk);
        ext_wr_in = 0;
        repeat (4) @(negedge clk);
        tests++;
        if (irq_status_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL race_set_wins got=%b want=1", irq_status_out);
        end
        wb_read(3, d);
        tests++;
        if (d !== 32'h0000_0077) begin
            fails++;
            $display("[TB] FAIL race_new_value got=%h want=00000077", d);
        end
        wb_write(2, 32'h3C);
        wb_read(2, d);
        tests++;
        if (d !== 32'h0000_003C) begin
            fails++;
            $display("[TB] FAIL host_stat_wb got=%h want=0000003c", d);
        end
        ext_access(1'b0, 2'd3, 8'h00);
        tests++;
        if (ext_data_out !== 8'h3C) begin
            fails++;
            $display("[TB] FAIL host_stat_ext got=%h want=3c", ext_data_out);
        end
        ext_access(1'b0, 2'd1, 8'h00);
        tests++;
        if (ext_data_out !== 8'h01) begin
            fails++;
            $display("[TB] FAIL ext_flags got=%h want=01", ext_data_out);
        end
        ext_access(1'b0, 2'd2, 8'h00);
        tests++;
        if (ext_data_out !== 8'h00) begin
            fails++;
            $display("[TB] FAIL ext_unmapped_read got=%h want=00", ext_data_out);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        apply_reset();
        wb_access(1'b1, 32'h4000_0000, 32'h99, d);
        wb_read(1, d);
        tests++;
        if (d !== 32'h0002_0000) begin
            fails++;
            $display("[TB] FAIL unmapped_write got=%h want=00020000", d);
        end
        wb_access(1'b0, 32'h4000_0004, 32'h0, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL unmapped_read got=%h want=00000000", d);
        end
        wb_write(2, 32'hFF);
        wb_read(6, d);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reserved_read got=%h want=00000000", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        apply_reset();
        wb_write(4, 32'h1);
        for (int i = 0; i < 4; i++) wb_write(0, 32'(8'h40 + i));
        ext_access(1'b0, 2'd0, 8'h00);
        ext_access(1'b1, 2'd0, 8'h66);
        ext_access(1'b1, 2'd0, 8'h67);
        tests++;
        if (ext_data_out !== 8'h40 || irq_data_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pre_reset got data=%h irqd=%b want 40 1", ext_data_out, irq_data_out);
        end
        @(negedge clk);
        wb_cyc_in = 1; wb_stb_in = 1; wb_we_in = 0; wb_addr_in = BASE + 32'h4;
        @(posedge clk); #1;
        tests++;
        if (wb_ack_out !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_ack got=%b want=1", wb_ack_out);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (wb_ack_out !== 1'b0 || ext_data_out !== 8'h00 || irq_data_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset got ack=%b data=%h irqd=%b want 0 00 0",
                     wb_ack_out, ext_data_out, irq_data_out);
        end
        wb_cyc_in = 0; wb_stb_in = 0;
        @(negedge clk);
        reset = 1'b0;
        wb_read(1, d);
        tests++;
        if (d !== 32'h0002_0000) begin
            fails++;
            $display("[TB] FAIL post_reset_status got=%h want=00020000", d);
        end
    endtask

    initial begin
        test_reset();
        test_h2e_basic();
        test_irq_data();
        test_overflow();
        test_status_mbox();
        test_unmapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
